// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: FSM state type,
// return-stack depth helper and the control opcodes it decodes.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

  localparam int unsigned SEQ_SP_LENGTH_DEFAULT = 5;

  // Return stack holds one entry per pointer value.
  function automatic int unsigned stack_depth(input int unsigned sp_len);
    return 32'd1 << sp_len;
  endfunction

  localparam int unsigned SEQ_STACK_DEPTH_DEFAULT = stack_depth(SEQ_SP_LENGTH_DEFAULT);

  // Control opcodes (instruction[15:12]); every other value is a cell ALU op.
  localparam logic [3:0] OP_JUMP = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_UNL  = 4'hD;

endpackage

// File: rtl/seq_return_stack.sv
// Return-address stack: synchronous write, asynchronous read, not reset.
module seq_return_stack
  import seq_pkg::*;
#(
  parameter int unsigned PC_LENGTH = 12,
  parameter int unsigned SP_LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SP_LENGTH-1:0] waddr,
  input  logic [PC_LENGTH-1:0] wdata,
  input  logic [SP_LENGTH-1:0] raddr,
  output logic [PC_LENGTH-1:0] rdata
);

  localparam int unsigned DEPTH = stack_depth(SP_LENGTH);

  logic [PC_LENGTH-1:0] mem [DEPTH];

  // Push writes the return address at the current pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches 16-bit instructions, broadcasts them to the
// cell array and handles JUMP/CALL/RET/UNL flow control.
// Build option: SEQ_STACK_CHECK_EN halts with a sticky stack_error on
// stack overflow/underflow instead of letting the pointer wrap.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_FETCH | fetch_addr = pc, wait for run, latch fetch_data
//   ST_EXEC  | instruction valid, pc/sp updated at the closing edge
//   ST_HALT  | stopped (self-jump or stack error), left only by rst
module program_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned N_CELLS   = 64,
  parameter int unsigned PC_LENGTH = 12,
  parameter int unsigned SP_LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [PC_LENGTH-1:0] fetch_addr,
  input  logic [15:0]          fetch_data,
  input  logic [N_CELLS-1:0]   diverge,
  output logic [15:0]          instruction,
  output logic                 execution_enable,
  output logic [PC_LENGTH-1:0] next_program_counter,
  output logic [SP_LENGTH-1:0] next_stack_pointer,
  output logic                 halted,
  output logic                 stack_error
);

  seq_state_t           state_q, state_d;
  logic [PC_LENGTH-1:0] pc_q, pc_d;
  logic [SP_LENGTH-1:0] sp_q, sp_d;
  logic [15:0]          instr_q;

  logic [3:0]           opcode;
  logic [PC_LENGTH-1:0] target, unl_target, pc_inc, ret_addr;
  logic [SP_LENGTH-1:0] sp_inc, sp_dec;
  logic                 push;
  logic                 err_set;

  assign opcode     = instr_q[15:12];
  assign target     = PC_LENGTH'(instr_q[11:0]);
  assign unl_target = PC_LENGTH'(instr_q[7:0]);
  assign pc_inc     = pc_q + PC_LENGTH'(1);
  assign sp_inc     = sp_q + SP_LENGTH'(1);
  assign sp_dec     = sp_q - SP_LENGTH'(1);

  seq_return_stack #(
    .PC_LENGTH (PC_LENGTH),
    .SP_LENGTH (SP_LENGTH)
  ) u_stack (
    .clk   (clk),
    .we    (push),
    .waddr (sp_q),
    .wdata (pc_inc),
    .raddr (sp_dec),
    .rdata (ret_addr)
  );

  // Next-state, next pc/sp and stack control.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    sp_d             = sp_q;
    push             = 1'b0;
    err_set          = 1'b0;
    execution_enable = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        execution_enable = 1'b1;
        state_d          = ST_FETCH;
        case (opcode)
          OP_JUMP: begin
            pc_d = target;
            if (target == pc_q) state_d = ST_HALT;
          end
          OP_CALL: begin
`ifdef SEQ_STACK_CHECK_EN
            if (sp_q == {SP_LENGTH{1'b1}}) begin
              err_set = 1'b1;
              state_d = ST_HALT;
            end else begin
              push = 1'b1;
              sp_d = sp_inc;
              pc_d = target;
            end
`else
            push = 1'b1;
            sp_d = sp_inc;
            pc_d = target;
`endif
          end
          OP_RET: begin
`ifdef SEQ_STACK_CHECK_EN
            if (sp_q == {SP_LENGTH{1'b0}}) begin
              err_set = 1'b1;
              state_d = ST_HALT;
            end else begin
              sp_d = sp_dec;
              pc_d = ret_addr;
            end
`else
            sp_d = sp_dec;
            pc_d = ret_addr;
`endif
          end
          OP_UNL:  pc_d = (&diverge) ? unl_target : pc_inc;
          default: pc_d = pc_inc;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // State, pc, sp and instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      sp_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      if (state_q == ST_FETCH && run) instr_q <= fetch_data;
    end
  end

`ifdef SEQ_STACK_CHECK_EN
  logic err_q;

  // Sticky stack error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign stack_error = err_q;
`else
  assign stack_error = 1'b0;
`endif

  // Presenting the next pc lets a synchronous program memory deliver the
  // word during the following FETCH cycle.
  assign fetch_addr           = pc_d;
  assign next_program_counter = pc_d;
  assign next_stack_pointer   = sp_d;
  assign instruction          = instr_q;
  assign halted               = (state_q == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus
// random programs compared against an instruction-level reference model.
module tb_program_sequencer;
  import seq_pkg::*;

  localparam int N_CELLS = 64;
  localparam int PC_MOD  = 4096;
  localparam int DEPTH   = 32;
`ifdef SEQ_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic [11:0]        fetch_addr;
  logic [15:0]        fetch_data;
  logic [N_CELLS-1:0] diverge;
  logic [15:0]        instruction;
  logic               execution_enable;
  logic [11:0]        next_program_counter;
  logic [4:0]         next_stack_pointer;
  logic               halted;
  logic               stack_error;

  program_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .run                  (run),
    .fetch_addr           (fetch_addr),
    .fetch_data           (fetch_data),
    .diverge              (diverge),
    .instruction          (instruction),
    .execution_enable     (execution_enable),
    .next_program_counter (next_program_counter),
    .next_stack_pointer   (next_stack_pointer),
    .halted               (halted),
    .stack_error          (stack_error)
  );

  always #5 clk = ~clk;

  // Synchronous program memory.
  logic [15:0] mem [PC_MOD];
  always @(posedge clk) fetch_data <= mem[fetch_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference machine state.
  int m_pc, m_sp;
  int m_stack [DEPTH];
  bit m_halt, m_err;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CELLS-1:0] rand_div();
    logic [N_CELLS-1:0] d;
    d = '1;
    if ($urandom_range(0, 1) == 0) d[$urandom_range(0, N_CELLS-1)] = 1'b0;
    return d;
  endfunction

  function automatic logic [15:0] rand_word();
    int r;
    logic [15:0] w;
    r = $urandom_range(0, 9);
    w = 16'($urandom());
    case (r)
      0, 1:    w = {OP_JUMP, 4'h0, w[7:0]};
      2:       w = {OP_CALL, 4'h0, w[7:0]};
      3:       w = {OP_RET,  w[11:0]};
      4, 5:    w = {OP_UNL,  w[11:0]};
      default: w = {4'($urandom_range(0, 9)), w[11:0]};
    endcase
    return w;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    run     = 1'b0;
    diverge = '1;
    m_pc = 0; m_sp = 0; m_halt = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Architectural effect of one instruction, checked against the DUT's
  // combinational next pc/sp during EXEC.
  task automatic model_exec(input logic [15:0] ins);
    int npc, nsp, imm;
    npc = (m_pc + 1) % PC_MOD;
    nsp = m_sp;
    imm = int'(ins[11:0]) % PC_MOD;
    case (ins[15:12])
      OP_JUMP: begin
        npc = imm;
        if (imm == m_pc) m_halt = 1'b1;
      end
      OP_CALL: begin
        if (CHK && m_sp == DEPTH-1) begin
          m_err = 1'b1; m_halt = 1'b1; npc = m_pc;
        end else begin
          m_stack[m_sp] = (m_pc + 1) % PC_MOD;
          nsp = (m_sp + 1) % DEPTH;
          npc = imm;
        end
      end
      OP_RET: begin
        if (CHK && m_sp == 0) begin
          m_err = 1'b1; m_halt = 1'b1; npc = m_pc;
        end else begin
          nsp = (m_sp + DEPTH - 1) % DEPTH;
          npc = m_stack[nsp];
        end
      end
      OP_UNL: if (diverge == {N_CELLS{1'b1}}) npc = int'(ins[7:0]);
      default: ;
    endcase
    chk(next_program_counter, npc, "exec_next_pc");
    chk(next_stack_pointer, nsp, "exec_next_sp");
    m_pc = npc;
    m_sp = nsp;
  endtask

  // Run one instruction from a FETCH-cycle negedge to the negedge after EXEC.
  task automatic run_one(input bit rand_run);
    int cyc;
    cyc = 0;
    while (execution_enable !== 1'b1 && cyc < 40) begin
      chk(fetch_addr, m_pc, "fetch_addr");
      if (rand_run) begin
        run     = ($urandom_range(0, 3) != 0);
        diverge = rand_div();
      end else begin
        run = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk(32'(cyc < 40), 32'd1, "exec_reached");
    if (cyc < 40) begin
      chk(instruction, mem[m_pc], "instruction");
      model_exec(mem[m_pc]);
      if (rand_run) run = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      chk(execution_enable, 0, "ee_after_exec");
      chk(halted, m_halt, "halted");
      chk(stack_error, m_err, "stack_error");
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; diverge = '1;
    for (int i = 0; i < PC_MOD; i++) mem[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < DEPTH; i++) m_stack[i] = 0;
    do_reset();

    // Reset state
    chk(execution_enable, 0, "rst_ee");
    chk(halted, 0, "rst_halted");
    chk(stack_error, 0, "rst_stack_error");
    chk(instruction, 0, "rst_instruction");
    chk(next_program_counter, 0, "rst_next_pc");
    chk(next_stack_pointer, 0, "rst_next_sp");
    chk(fetch_addr, 0, "rst_fetch_addr");

    // Straight-line ALU words: enable every other cycle
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk(fetch_addr, k, "seq_fetch_addr");
      chk(execution_enable, 0, "seq_ee_fetch");
      @(negedge clk);
      chk(execution_enable, 1, "seq_ee_exec");
      chk(instruction, 16'h1000 + 16'(k), "seq_instruction");
      chk(next_program_counter, k + 1, "seq_next_pc");
      @(negedge clk);
    end

    // CALL / RET
    rst = 1'b1;
    mem[0]     = {OP_JUMP, 12'h005};
    mem[5]     = {OP_CALL, 12'h010};
    mem[12'h10] = {OP_RET, 12'h000};
    do_reset();
    run_one(1'b0);
    run_one(1'b0);
    chk(next_program_counter, 12'h010, "call_pc");
    chk(next_stack_pointer, 1, "call_sp");
    run_one(1'b0);
    chk(next_program_counter, 6, "ret_pc");
    chk(next_stack_pointer, 0, "ret_sp");
    run_one(1'b0);
    chk(next_program_counter, 7, "after_ret_pc");

    // UNL taken / not taken
    rst = 1'b1;
    mem[0]      = {OP_UNL, 4'h0, 8'h20};
    mem[12'h20] = {OP_UNL, 4'h0, 8'h55};
    do_reset();
    diverge = '1;
    run_one(1'b0);
    chk(next_program_counter, 12'h020, "unl_taken_pc");
    diverge[17] = 1'b0;
    run_one(1'b0);
    chk(next_program_counter, 12'h021, "unl_not_taken_pc");

    // Self-jump halt
    rst = 1'b1;
    for (int i = 0; i < 7; i++) mem[i] = 16'h2000 + 16'(i);
    mem[7] = {OP_JUMP, 12'h007};
    do_reset();
    diverge = '1;
    repeat (7) run_one(1'b0);
    chk(fetch_addr, 7, "halt_fetch_addr");
    run = 1'b1;
    @(negedge clk);
    chk(execution_enable, 1, "halt_jump_exec");
    @(negedge clk);
    chk(halted, 1, "halt_after_2");
    repeat (3) begin
      @(negedge clk);
      chk(execution_enable, 0, "halt_ee");
      chk(next_program_counter, 7, "halt_pc_frozen");
    end
    chk(halted, 1, "halt_sticky");

    // Asynchronous reset during EXEC of a CALL
    rst = 1'b1;
    mem[0] = {OP_CALL, 12'h020};
    do_reset();
    run = 1'b1;
    @(negedge clk);
    chk(execution_enable, 1, "arst_in_exec");
    rst = 1'b1;
    #1;
    chk(next_program_counter, 0, "arst_pc");
    chk(next_stack_pointer, 0, "arst_sp");
    chk(execution_enable, 0, "arst_ee");
    chk(instruction, 0, "arst_instruction");

    // Deep CALL nesting: overflow check or pointer wrap
    for (int k = 0; k < 64; k++) mem[k] = {OP_CALL, 12'(k + 1)};
    do_reset();
    repeat (32) run_one(1'b0);
`ifdef SEQ_STACK_CHECK_EN
    chk(stack_error, 1, "ovf_stack_error");
    chk(halted, 1, "ovf_halted");
    chk(next_stack_pointer, 31, "ovf_sp");
`else
    chk(next_stack_pointer, 0, "wrap_sp");
    chk(next_program_counter, 32, "wrap_pc");
    chk(stack_error, 0, "wrap_no_error");
`endif

    // Random programs against the reference model
    for (int p = 0; p < 6; p++) begin
      rst = 1'b1;
      for (int i = 0; i < PC_MOD; i++) mem[i] = rand_word();
      do_reset();
      for (int i = 0; i < 150 && !m_halt; i++) run_one(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
